// File: rtl/rs422_pkg.sv
// Shared types and constants for the RS422 link blocks: serializer state
// encoding and parity-sense constants.
package rs422_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/rs422_tx_byte.sv
// RS422 byte serializer: valid/ready byte in, idle-high LSB-first line out,
// bit timing from the baud counter strobe. Optional parity bit: RS422_TX_PARITY_EN.
import rs422_pkg::*;

module rs422_tx_byte #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_pulse,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 baud_sync,
  output logic                 txd,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  tx_state_t            r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [CW-1:0]        r_bitCnt;
  logic                 r_txd;
  logic                 r_ready;
  logic                 r_sync;
  logic                 r_busy;
  logic [DATA_BITS-1:0] w_shiftNext;

`ifdef RS422_TX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  logic r_parity;
`else
  logic w_unusedParitySense;
  assign w_unusedParitySense = (PARITY_ODD != 0);
`endif

  assign w_shiftNext = r_shift >> 1;

  // The bit counter is cleared on leaving DATA so it can count stop periods too.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitCnt <= '0;
      r_txd    <= 1'b1;
      r_ready  <= 1'b1;
      r_sync   <= 1'b0;
      r_busy   <= 1'b0;
`ifdef RS422_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_sync <= 1'b0;
      case (r_state)
        IDLE: begin
          if (tx_valid && r_ready) begin
            r_shift  <= tx_data;
            r_bitCnt <= '0;
            r_state  <= START;
            r_txd    <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_sync   <= 1'b1;
`ifdef RS422_TX_PARITY_EN
            r_parity <= (^tx_data) ^ PAR_SENSE;
`endif
          end
        end
        START: begin
          if (baud_pulse) begin
            r_state <= DATA;
            r_txd   <= r_shift[0];
          end
        end
        DATA: begin
          if (baud_pulse) begin
            r_shift <= w_shiftNext;
            if (r_bitCnt == LAST_DATA) begin
              r_bitCnt <= '0;
`ifdef RS422_TX_PARITY_EN
              r_state  <= PARITY;
              r_txd    <= r_parity;
`else
              r_state  <= STOP;
              r_txd    <= 1'b1;
`endif
            end else begin
              r_bitCnt <= r_bitCnt + CW'(1);
              r_txd    <= w_shiftNext[0];
            end
          end
        end
`ifdef RS422_TX_PARITY_EN
        PARITY: begin
          if (baud_pulse) begin
            r_state <= STOP;
            r_txd   <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_pulse) begin
            if (r_bitCnt == LAST_STOP) begin
              r_state  <= IDLE;
              r_bitCnt <= '0;
              r_ready  <= 1'b1;
              r_busy   <= 1'b0;
            end else begin
              r_bitCnt <= r_bitCnt + CW'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_txd   <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready  = r_ready;
  assign baud_sync = r_sync;
  assign txd       = r_txd;
  assign busy      = r_busy;

endmodule
